// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of one single-port word RAM between fetch and load/store ports
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [31:0]           if_req_addr,
  output logic                  if_rsp_valid,
  input  logic                  if_rsp_ready,
  output logic [31:0]           if_rsp_data,
  output logic                  if_rsp_err,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [2:0]            d_req_funct3,
  input  logic [31:0]           d_req_addr,
  input  logic [31:0]           d_req_wdata,
  output logic                  d_rsp_valid,
  input  logic                  d_rsp_ready,
  output logic [31:0]           d_rsp_rdata,
  output logic                  d_rsp_err,
  output logic                  ram_wr_en,
  output logic [3:0]            ram_wr_strobe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out
);
  localparam int HI = ADDR_WIDTH + 2;
  logic last_grant;
  logic if_elig, d_elig, g_if, g_d, if_err, d_err, is_h, is_w, d_ok, wr, sgn;
  logic [7:0] b_lane;
  logic [15:0] h_lane;
  logic [31:0] ld;
  always_comb begin
    if_elig = ~rst & if_req_valid & (~if_rsp_valid | if_rsp_ready);
    d_elig = ~rst & d_req_valid & (~d_rsp_valid | d_rsp_ready);
    g_if = if_elig & (~d_elig | last_grant);
    g_d = d_elig & ~g_if;
    if_req_ready = g_if;
    d_req_ready = g_d;
    if_err = (|if_req_addr[1:0]) | (|if_req_addr[31:HI]);
    is_h = d_req_funct3[1:0] == 2'b01;
    is_w = d_req_funct3 == 3'b010;
    d_err = (d_req_funct3 == 3'b011) | (&d_req_funct3[2:1]) | (d_req_we & d_req_funct3[2])
          | (is_h & d_req_addr[0]) | (is_w & |d_req_addr[1:0]) | (|d_req_addr[31:HI]);
    d_ok = g_d & ~d_err;
    wr = d_ok & d_req_we;
    ram_wr_en = wr;
    ram_addr = (g_if & ~if_err) ? if_req_addr[HI-1:2] : d_ok ? d_req_addr[HI-1:2] : '0;
    ram_wr_strobe = ~wr ? 4'b0000 : is_w ? 4'b1111
                  : is_h ? 4'b0011 << {d_req_addr[1], 1'b0} : 4'b0001 << d_req_addr[1:0];
    ram_data_in = ~wr ? 32'h0 : is_w ? d_req_wdata
                : is_h ? {2{d_req_wdata[15:0]}} : {4{d_req_wdata[7:0]}};
    b_lane = ram_data_out[{d_req_addr[1:0], 3'b000} +: 8];
    h_lane = ram_data_out[{d_req_addr[1], 4'b0000} +: 16];
    sgn = ~d_req_funct3[2];
    ld = is_w ? ram_data_out : is_h ? {{16{sgn & h_lane[15]}}, h_lane} : {{24{sgn & b_lane[7]}}, b_lane};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      if_rsp_valid <= 1'b0;
      if_rsp_data <= '0;
      if_rsp_err <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_rdata <= '0;
      d_rsp_err <= 1'b0;
    end else begin
      if (g_if | g_d) last_grant <= g_d;
      if (g_if) begin
        if_rsp_valid <= 1'b1;
        if_rsp_data <= if_err ? 32'h0 : ram_data_out;
        if_rsp_err <= if_err;
      end else if (if_rsp_ready) if_rsp_valid <= 1'b0;
      if (g_d) begin
        d_rsp_valid <= 1'b1;
        d_rsp_rdata <= (d_err | d_req_we) ? 32'h0 : ld;
        d_rsp_err <= d_err;
      end else if (d_rsp_ready) d_rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: random traffic on both ports checked against a byte-level memory model
module tb_ram_port_arbiter;
  localparam int AW = 16;
  localparam int NB = 1 << (AW + 2);
  logic clk = 1'b0, rst;
  logic if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [31:0] if_req_addr, if_rsp_data;
  logic d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [2:0] d_req_funct3;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic ram_wr_en;
  logic [3:0] ram_wr_strobe;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_data_in, ram_data_out;
  logic [31:0] ram [0:(1<<AW)-1];
  logic [7:0] mb [0:NB-1];
  int tests = 0, fails = 0;
  bit if_pend, d_pend, last_d, if_hold, d_hold, if_exp_e, d_exp_e;
  logic [31:0] if_exp, d_exp;

  ram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we), .d_req_funct3(d_req_funct3),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .ram_wr_en(ram_wr_en), .ram_wr_strobe(ram_wr_strobe), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;
  assign ram_data_out = ram[ram_addr];
  always @(posedge clk)
    if (ram_wr_en)
      for (int i = 0; i < 4; i++)
        if (ram_wr_strobe[i]) ram[ram_addr][8*i +: 8] <= ram_data_in[8*i +: 8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_addr(input bit fetch);
    logic [31:0] a;
    a = $urandom_range(0, 63);
    if (fetch && $urandom_range(0, 4) != 0) a = a & ~32'h3;
    case ($urandom_range(0, 11))
      0: a = a | (32'h1 << $urandom_range(AW + 2, 31));
      1: a = $urandom;
      2: a = fetch ? 32'h102 : a;
      default: ;
    endcase
    return a;
  endfunction

  task automatic step();
    bit el_if, el_d, g_if, g_d, err, exp_we;
    int sz;
    logic [31:0] a, rd, exp_din;
    logic [3:0] exp_stb;
    logic [AW-1:0] exp_addr;
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(if_pend));
    check("d_rsp_valid", 32'(d_rsp_valid), 32'(d_pend));
    if (if_pend) begin
      check("if_rsp_data", if_rsp_data, if_exp);
      check("if_rsp_err", 32'(if_rsp_err), 32'(if_exp_e));
    end
    if (d_pend) begin
      check("d_rsp_rdata", d_rsp_rdata, d_exp);
      check("d_rsp_err", 32'(d_rsp_err), 32'(d_exp_e));
    end
    el_if = !rst && if_req_valid && (!if_pend || if_rsp_ready);
    el_d = !rst && d_req_valid && (!d_pend || d_rsp_ready);
    g_if = el_if && (!el_d || last_d);
    g_d = el_d && !g_if;
    check("if_req_ready", 32'(if_req_ready), 32'(g_if));
    check("d_req_ready", 32'(d_req_ready), 32'(g_d));
    exp_we = 0; exp_stb = 0; exp_addr = 0; exp_din = 0;
    if (g_if) begin
      a = if_req_addr;
      err = (a % 4 != 0) || (a >= NB);
      rd = 0;
      if (!err) begin
        for (int i = 0; i < 4; i++) rd[8*i +: 8] = mb[a + i];
        exp_addr = AW'(a / 4);
      end
      if_exp = rd; if_exp_e = err;
    end
    if (g_d) begin
      a = d_req_addr;
      sz = 1 << d_req_funct3[1:0];
      err = (d_req_funct3 == 3 || d_req_funct3 >= 6) || (d_req_we && d_req_funct3 >= 4)
         || (a % sz != 0) || (a >= NB);
      rd = 0;
      if (!err) begin
        exp_addr = AW'(a / 4);
        if (d_req_we) begin
          exp_we = 1;
          for (int i = 0; i < 4; i++) exp_din[8*i +: 8] = d_req_wdata[8*(i % sz) +: 8];
          for (int i = 0; i < sz; i++) begin
            exp_stb[a % 4 + i] = 1'b1;
            mb[a + i] = d_req_wdata[8*i +: 8];
          end
        end else begin
          for (int i = 0; i < sz; i++) rd[8*i +: 8] = mb[a + i];
          if (d_req_funct3 < 4 && sz < 4 && rd[8*sz-1]) rd = rd | (32'hFFFFFFFF << (8*sz));
        end
      end
      d_exp = rd; d_exp_e = err;
    end
    check("ram_wr_en", 32'(ram_wr_en), 32'(exp_we));
    check("ram_wr_strobe", 32'(ram_wr_strobe), 32'(exp_stb));
    check("ram_addr", 32'(ram_addr), 32'(exp_addr));
    check("ram_data_in", ram_data_in, exp_din);
    if (rst) begin
      if_pend = 0; d_pend = 0; last_d = 1;
    end else begin
      if_pend = g_if || (if_pend && !if_rsp_ready);
      d_pend = g_d || (d_pend && !d_rsp_ready);
      if (g_if || g_d) last_d = g_d;
    end
    if_hold = !rst && if_req_valid && !g_if;
    d_hold = !rst && d_req_valid && !g_d;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    for (int i = 0; i < NB; i++) mb[i] = 8'h0;
    rst = 1; if_req_valid = 0; if_req_addr = 0; if_rsp_ready = 0;
    d_req_valid = 0; d_req_we = 0; d_req_funct3 = 0; d_req_addr = 0; d_req_wdata = 0; d_rsp_ready = 0;
    if_hold = 0; d_hold = 0; if_pend = 0; d_pend = 0; last_d = 1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst = (c < 2) || (c >= 2000 && c < 2003);
      if (!if_hold) begin
        if_req_valid = $urandom_range(0, 3) != 0;
        if_req_addr = pick_addr(1);
      end
      if (!d_hold) begin
        d_req_valid = $urandom_range(0, 3) != 0;
        d_req_we = $urandom_range(0, 2) == 0;
        d_req_funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
        if (!d_req_we && $urandom_range(0, 2) == 0) d_req_funct3 = 3'($urandom_range(4, 5));
        d_req_addr = pick_addr(0);
        d_req_wdata = $urandom;
      end
      if_rsp_ready = $urandom_range(0, 3) != 0;
      d_rsp_ready = (c >= 1994 && c < 2003) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (c == 2 || c == 2003) begin
        check("reset if_rsp_data", if_rsp_data, 32'h0);
        check("reset if_rsp_err", 32'(if_rsp_err), 32'h0);
        check("reset d_rsp_rdata", d_rsp_rdata, 32'h0);
        check("reset d_rsp_err", 32'(d_rsp_err), 32'h0);
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
